// File: rtl/db_arbiter_pkg.sv
// Shared types and constants for the two-requester data-break arbiter.
package db_arbiter_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned STATE_W = 5;

  // CPU major-state codes shared with the processor core
  localparam logic [STATE_W-1:0] DB1 = 5'd6;
  localparam logic [STATE_W-1:0] DB2 = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BRK  = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_e;

  // Saturating increment for the break timeout counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/db_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the requester not served last wins.
module rr_pick
  import db_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] win_c
);

  // One-hot winner; last == 1 means requester 1 was served most recently
  always_comb begin
    win_c = 2'b00;
    if (req0 && (!req1 || last)) begin
      win_c = 2'b01;
    end else if (req1) begin
      win_c = 2'b10;
    end
  end

endmodule

// File: rtl/db_arbiter.sv
// Arbitrates two DMA requesters onto the CPU data-break interface.
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter logic [9:0] TMO_CYCLES = 10'd1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [4:0]    state,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [0:14]   addr0,
  input  logic [0:14]   addr1,
  input  logic [0:11]   dout0,
  input  logic [0:11]   dout1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic          data_break,
  output logic          to_disk,
  output logic [0:14]   dmaAddr,
  output logic [0:11]   dmaDOUT
);

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             data_break_q, data_break_d;
  logic             to_disk_q, to_disk_d;
  logic [0:14]      dma_addr_q, dma_addr_d;
  logic [0:11]      dma_dout_q, dma_dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       win_c;
  logic             owner_req_c;
  logic             rst_c;

  assign rst_c       = reset | clear;
  assign owner_req_c = (gnt_q[0] & req0) | (gnt_q[1] & req1);

  rr_pick u_rr_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .win_c (win_c)
  );

  // State and output registers; IOCLR behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst_c) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      data_break_q <= 1'b0;
      to_disk_q    <= 1'b0;
      dma_addr_q   <= 15'o00000;
      dma_dout_q   <= 12'o0000;
      cnt_q        <= '0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      data_break_q <= data_break_d;
      to_disk_q    <= to_disk_d;
      dma_addr_q   <= dma_addr_d;
      dma_dout_q   <= dma_dout_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    err_d        = 2'b00;
    data_break_d = data_break_q;
    to_disk_d    = to_disk_q;
    dma_addr_d   = dma_addr_q;
    dma_dout_d   = dma_dout_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d        = 2'b00;
        data_break_d = 1'b0;
        if (req0 || req1) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_c != 2'b00) begin
          gnt_d        = win_c;
          dma_addr_d   = win_c[1] ? addr1 : addr0;
          dma_dout_d   = win_c[1] ? dout1 : dout0;
          to_disk_d    = win_c[1] ? ~wr1 : ~wr0;
          cnt_d        = '0;
          data_break_d = 1'b1;
          state_d      = ST_BRK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BRK: begin
        cnt_d = sat_inc(cnt_q);
        // DB2 takes priority over a coincident timeout
        if (state == DB2) begin
          data_break_d = 1'b0;
          done_d       = gnt_q;
          last_d       = gnt_q[1];
          state_d      = ST_ACK;
        end else if (cnt_d >= TMO_CYCLES) begin
          data_break_d = 1'b0;
          err_d        = gnt_q;
          last_d       = gnt_q[1];
          state_d      = ST_ACK;
        end
      end
      ST_ACK: begin
        data_break_d = 1'b0;
        if (!owner_req_c) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign done0      = done_q[0];
  assign done1      = done_q[1];
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign data_break = data_break_q;
  assign to_disk    = to_disk_q;
  assign dmaAddr    = dma_addr_q;
  assign dmaDOUT    = dma_dout_q;

endmodule

// File: tb/tb_db_arbiter.sv
// Directed self-checking bench for db_arbiter (timeout set to 8 cycles).
module tb_db_arbiter;
  import db_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [4:0]  state_in;
  logic        req0, req1, wr0, wr1;
  logic [0:14] addr0, addr1;
  logic [0:11] dout0, dout1;
  logic        gnt0, gnt1, done0, done1, err0, err1, data_break, to_disk;
  logic [0:14] dmaAddr;
  logic [0:11] dmaDOUT;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  db_arbiter #(.TMO_CYCLES(10'd8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .state(state_in),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .dout0(dout0), .dout1(dout1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .data_break(data_break), .to_disk(to_disk),
    .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Wait for a grant, complete it with DB2, then cycle the owner's request
  task automatic serve(input int who, input string tag);
    int n;
    n = 0;
    while (!(gnt0 || gnt1) && n < 10) begin
      tick();
      chk({tag, "_not_both"}, 32'(gnt0 && gnt1), 32'd0);
      n++;
    end
    chk({tag, "_gnt_seen"}, 32'(gnt0 || gnt1), 32'd1);
    chk({tag, "_owner"}, 32'({gnt1, gnt0}), (who == 0) ? 32'd1 : 32'd2);
    state_in = DB2;
    tick();
    state_in = 5'd0;
    chk({tag, "_done"}, 32'({done1, done0}), (who == 0) ? 32'd1 : 32'd2);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk({tag, "_released"}, 32'({gnt1, gnt0}), 32'd0);
    if (who == 0) req0 = 1'b1; else req1 = 1'b1;
  endtask

  initial begin
    int hi;
    reset = 1'b1; clear = 1'b0; state_in = 5'd0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; dout0 = '0; dout1 = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_db", 32'(data_break), 32'd0);
    chk("rst_addr", 32'(dmaAddr), 32'd0);

    // single write break with DB2 after three cycles
    req0 = 1'b1; wr0 = 1'b1; addr0 = 15'o12345; dout0 = 12'o7070;
    tick();
    chk("t1_db_lat1", 32'(data_break), 32'd0);
    tick();
    chk("t1_db_lat2", 32'(data_break), 32'd1);
    chk("t1_gnt", 32'({gnt1, gnt0}), 32'd1);
    chk("t1_addr", 32'(dmaAddr), 32'(15'o12345));
    chk("t1_dout", 32'(dmaDOUT), 32'(12'o7070));
    chk("t1_to_disk", 32'(to_disk), 32'd0);
    tick(); tick();
    state_in = DB2;
    tick();
    state_in = 5'd0;
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_no_err", 32'(err0), 32'd0);
    chk("t1_db_off", 32'(data_break), 32'd0);
    tick();
    chk("t1_done_once", 32'(done0), 32'd0);
    chk("t1_gnt_held", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    chk("t1_idle_gnt", 32'(gnt0), 32'd0);
    chk("t1_addr_stable", 32'(dmaAddr), 32'(15'o12345));

    // round-robin with both requesters held
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr1 = 15'o00042;
    serve(0, "rr_a");
    serve(1, "rr_b");
    serve(0, "rr_c");
    serve(1, "rr_d");
    req0 = 1'b0; req1 = 1'b0;

    // timeout on requester 1 (read direction)
    do_reset();
    req1 = 1'b1; wr1 = 1'b0; addr1 = 15'o54321;
    tick(); tick();
    chk("t3_gnt1", 32'(gnt1), 32'd1);
    chk("t3_to_disk", 32'(to_disk), 32'd1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!data_break) break;
      hi++;
      tick();
    end
    chk("t3_brk_cycles", 32'(hi), 32'd8);
    chk("t3_err1", 32'(err1), 32'd1);
    chk("t3_no_done1", 32'(done1), 32'd0);
    tick();
    chk("t3_err_once", 32'(err1), 32'd0);
    req1 = 1'b0;
    tick();

    // reset in the middle of a break
    do_reset();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 15'o77777; dout0 = 12'o1234;
    tick(); tick(); tick();
    chk("t4_pre_to_disk", 32'(to_disk), 32'd1);
    reset = 1'b1;
    tick();
    chk("t4_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("t4_db", 32'(data_break), 32'd0);
    chk("t4_to_disk", 32'(to_disk), 32'd0);
    chk("t4_addr", 32'(dmaAddr), 32'd0);
    chk("t4_dout", 32'(dmaDOUT), 32'd0);
    chk("t4_pulses", 32'({done1, done0, err1, err0}), 32'd0);
    reset = 1'b0; req0 = 1'b0;
    tick();
    chk("t4_after_pulses", 32'({done1, done0, err1, err0}), 32'd0);
    chk("t4_after_gnt", 32'({gnt1, gnt0, data_break}), 32'd0);

    // DB2 coincides with timeout, started from IOCLR
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req0 = 1'b1; wr0 = 1'b1;
    tick(); tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t5_db_still", 32'(data_break), 32'd1);
    state_in = DB2;
    tick();
    state_in = 5'd0;
    chk("t5_done", 32'(done0), 32'd1);
    chk("t5_no_err", 32'(err0), 32'd0);
    req0 = 1'b0;
    tick();

    // owner drops req in BRK; non-owner ignored until idle
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 15'o00777;
    tick(); tick();
    req0 = 1'b0; req1 = 1'b1;
    tick(); tick();
    chk("t6_db_kept", 32'(data_break), 32'd1);
    chk("t6_gnt1_ignored", 32'(gnt1), 32'd0);
    state_in = DB2;
    tick();
    state_in = 5'd0;
    chk("t6_done", 32'(done0), 32'd1);
    chk("t6_gnt0", 32'({gnt1, gnt0}), 32'd1);
    tick();
    chk("t6_idle", 32'({gnt1, gnt0}), 32'd0);
    tick(); tick();
    chk("t6_gnt1_next", 32'({gnt1, gnt0}), 32'd2);
    req1 = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
